// File: rtl/ec_mem_ctrl_if.sv
// SRAM-like data bus between the ec-stage memory controller and the data memory.
// Request phase: req/wr/size/addr/wdata held until addr_ok.
// Response phase: data_ok/rdata, returned strictly after the request's addr_ok.
interface ec_mem_ctrl_if;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/ec_mem_ctrl.sv
// ec-stage data-side memory access controller.
// Issues one bus transaction per ec memory instruction, holds the pipeline
// until the response is in, and presents the response to the ec->wb register.
// Responses that belong to an instruction killed by refresh are drained and
// dropped, so a new access never overlaps a stale outstanding response.
module ec_mem_ctrl (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          refresh,
   input  logic          mem_en,
   input  logic          mem_wen,
   input  logic [1:0]    mem_size,
   input  logic [31:0]   mem_addr,
   input  logic [31:0]   mem_wdata,
   output logic          mem_stall,
   ec_mem_ctrl_if.master bus,
   output logic          ec_data_ok,
   output logic [31:0]   ec_data_rdata
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t      state_q;
   logic        killed_q;
   logic        data_req_q;
   logic        data_wr_q;
   logic [1:0]  data_size_q;
   logic [31:0] data_addr_q;
   logic [31:0] data_wdata_q;
   logic        ec_data_ok_q;
   logic [31:0] ec_data_rdata_q;

   // Transaction FSM with registered bus request and response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         killed_q        <= 1'b0;
         data_req_q      <= 1'b0;
         data_wr_q       <= 1'b0;
         data_size_q     <= 2'd0;
         data_addr_q     <= 32'd0;
         data_wdata_q    <= 32'd0;
         ec_data_ok_q    <= 1'b0;
         ec_data_rdata_q <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               killed_q <= 1'b0;
               if (mem_en && !refresh) begin
                  data_req_q   <= 1'b1;
                  data_wr_q    <= mem_wen;
                  data_size_q  <= mem_size;
                  data_addr_q  <= mem_addr;
                  data_wdata_q <= mem_wdata;
                  state_q      <= S_REQ;
               end
            end
            S_REQ: begin
               // The request cannot be withdrawn once presented; a kill is
               // remembered and resolved after the bus accepts it.
               if (bus.data_addr_ok) begin
                  data_req_q <= 1'b0;
                  if (refresh || killed_q) state_q <= S_DRAIN;
                  else                     state_q <= S_WAIT;
               end else if (refresh) begin
                  killed_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (bus.data_data_ok) begin
                  if (refresh) begin
                     killed_q <= 1'b0;
                     state_q  <= S_IDLE;
                  end else begin
                     ec_data_ok_q    <= 1'b1;
                     ec_data_rdata_q <= bus.data_rdata;
                     state_q         <= S_DONE;
                  end
               end else if (refresh) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (bus.data_data_ok) begin
                  killed_q <= 1'b0;
                  state_q  <= S_IDLE;
               end
            end
            S_DONE: begin
               if (!stall || refresh) begin
                  ec_data_ok_q <= 1'b0;
                  killed_q     <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               killed_q   <= 1'b0;
               data_req_q <= 1'b0;
            end
         endcase
      end
   end

   // Pipeline hold: a new access about to issue, or any transaction in flight.
   always_comb begin
      mem_stall = ((state_q == S_IDLE) && mem_en && !refresh) ||
                  (state_q == S_REQ) || (state_q == S_WAIT) ||
                  (state_q == S_DRAIN);
   end

   assign bus.data_req   = data_req_q;
   assign bus.data_wr    = data_wr_q;
   assign bus.data_size  = data_size_q;
   assign bus.data_addr  = data_addr_q;
   assign bus.data_wdata = data_wdata_q;
   assign ec_data_ok     = ec_data_ok_q;
   assign ec_data_rdata  = ec_data_rdata_q;

endmodule

// File: doc/ec_mem_ctrl.md
# ec_mem_ctrl

Data-side memory access controller for the exception-commit (ec) stage. It turns the ec stage's load/store request into an SRAM-like data-bus transaction (req/addr_ok, then data_ok/rdata). It holds the pipeline until the response arrives and presents `ec_data_ok`/`ec_data_rdata` to the ec→wb segment register. It is the producer side of the load-data path that wb consumes, and it discards responses belonging to instructions flushed by `refresh`.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: single clock
- `reset` in 1: reset, synchronous, active-high
- `stall` in 1: ec→wb segment not advancing this cycle
- `refresh` in 1: pipeline flush (exception/eret); kills the current ec instruction
- `mem_en` in 1: ec instruction performs a memory access
- `mem_wen` in 1: access is a store
- `mem_size` in 2: 0 = byte, 1 = half, 2 = word
- `mem_addr` in 32: byte address, already aligned per size
- `mem_wdata` in 32: store data, already lane-shifted upstream
- `mem_stall` out 1: request pipeline hold (combinational)
- `data_req` out 1: bus request valid
- `data_wr` out 1: bus write
- `data_size` out 2: bus size
- `data_addr` out 32: bus address
- `data_wdata` out 32: bus write data
- `data_addr_ok` in 1: request accepted
- `data_data_ok` in 1: response valid
- `data_rdata` in 32: response data
- `ec_data_ok` out 1: response held for ec→wb
- `ec_data_rdata` out 32: captured load data

## Operation
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - If `mem_en && !refresh`, latch `mem_wen`, `mem_size`, `mem_addr`, `mem_wdata` into the `data_*` registers and go to REQ.
  - If `refresh` is high, stay in IDLE.
- REQ:
  - `data_req`=1 and the `data_*` outputs are stable.
  - `data_req` is never withdrawn before `data_addr_ok`.
  - On `data_addr_ok`: go to DRAIN if `refresh` is high this cycle or an earlier kill flag is set; otherwise go to WAIT.
  - With no `data_addr_ok`, a `refresh` sets the internal `killed` flag and the FSM stays in REQ.
- WAIT:
  - `data_req`=0.
  - On `data_data_ok` without `refresh`: capture `data_rdata` into `ec_data_rdata`, set `ec_data_ok`, go to DONE.
  - On `data_data_ok` with `refresh`: go to IDLE with no capture.
  - `refresh` without `data_data_ok`: go to DRAIN.
- DRAIN: wait for `data_data_ok`, discard the data, go to IDLE. `ec_data_ok` stays 0.
- DONE:
  - `ec_data_ok`=1 and `ec_data_rdata` are held.
  - On `!stall` or `refresh`: clear `ec_data_ok`, go to IDLE.
  - For stores, `ec_data_ok` also pulses through DONE; `ec_data_rdata` takes the bus value, and the value is don't-care.
- `mem_stall` = (IDLE & `mem_en` & !`refresh`) | REQ | WAIT | DRAIN.
  - DRAIN stalls so that a new access is not issued while a stale response is outstanding.
- `killed` clears on any entry to IDLE.
- `data_addr_ok` is ignored outside REQ. `data_data_ok` is ignored in IDLE, REQ and DONE; a response never arrives in the same cycle as its own `addr_ok`.

## Timing
- Reset values: state IDLE, `killed` 0, `data_req` 0, `data_wr` 0, `data_size` 0, `data_addr` 0, `data_wdata` 0, `ec_data_ok` 0, `ec_data_rdata` 0. `mem_stall` follows its equation: 0 while `mem_en`=0.
- Reset in any state returns to IDLE next edge. An outstanding bus response after reset is the bus's responsibility.
- Minimum latency, `mem_en` to `ec_data_ok`:
  - cycle 0: IDLE latches the request.
  - cycle 1: REQ, `addr_ok`.
  - cycle 2: WAIT, `data_ok`.
  - cycle 3: DONE, `ec_data_ok`=1.
- Back-to-back accesses: one IDLE cycle between DONE and the next REQ.
- Simultaneous events:
  - `refresh` beats `data_data_ok` capture.
  - In DONE, `refresh` and `!stall` both lead to IDLE.

## Test plan
- **Load, zero wait:** `mem_en`=1, `mem_wen`=0, `mem_addr`=0x8000_0010, size 2; `addr_ok` in cycle 1, `data_ok` with rdata 0xDEAD_BEEF in cycle 2.
  - `data_req` is high exactly 1 cycle.
  - `ec_data_ok`=1 and `ec_data_rdata`=0xDEAD_BEEF in cycle 3.
  - `mem_stall` is high in cycles 0–2 and low in cycle 3.
- **Store with 3-cycle addr_ok delay:** `mem_wen`=1, `mem_wdata`=0x1234_5678.
  - `data_req`/`data_wr`/`data_addr`/`data_wdata` stay constant all 3 cycles.
  - `data_req` drops the cycle after `addr_ok`.
- **Stall in DONE:** `stall`=1 for 4 cycles after `data_ok`.
  - `ec_data_ok` and the rdata are held 4 cycles.
  - Return to IDLE on the first `!stall` edge.
- **Refresh in WAIT:** `refresh` pulses before `data_ok`.
  - FSM moves to DRAIN.
  - `data_ok` arriving 2 cycles later is discarded; `ec_data_ok` never asserts.
  - `mem_stall` is high until IDLE.
- **Refresh in REQ before addr_ok:**
  - `data_req` stays 1 until `addr_ok`, then DRAIN; the following `data_ok` is discarded.
  - A new `mem_en` is then issued correctly from IDLE.
- **Reset mid-WAIT:** `reset` pulses.
  - All outputs match their reset values next cycle.
  - State is IDLE and `mem_stall`=0 with `mem_en`=0.
